// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter datapath and its output buffer.
//   FIR_DW             : sample width produced by the filter
//   fir_sample_t       : one filter output sample
//   FIR_OUT_FIFO_DEPTH : default number of entries in the output buffer
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_DW             = 8;
    localparam int FIR_OUT_FIFO_DEPTH = 8;

    typedef logic [FIR_DW-1:0] fir_sample_t;

endpackage

// File: rtl/fifo_regfile.sv
// ---------------------------------------------------------------------------
// fifo_regfile
// DEPTH x DW register array used as FIFO storage. One synchronous write
// port and one asynchronous (combinational) read port. Contents are not
// reset; the owning FIFO tracks which entries are meaningful.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
// ---------------------------------------------------------------------------
module fifo_regfile #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_fifo.sv
// ---------------------------------------------------------------------------
// fir_out_fifo
// Output buffer behind the FIR filter. Every valid filter sample is captured
// and offered downstream through a valid/ready handshake with first-word-
// fall-through timing. The filter cannot be stalled, so a sample arriving
// while the buffer is full (and nothing leaves that cycle) is dropped and a
// sticky overflow flag is raised.
// Ports:
//   CLK      : clock, rising edge
//   RST_n    : asynchronous active-low reset
//   DIN      : sample from the filter
//   VIN      : DIN valid (single-cycle, no upstream ready)
//   DOUT     : head-of-queue sample, 0 when empty
//   VOUT     : DOUT valid (not empty)
//   RDY      : consumer takes DOUT this cycle
//   LEVEL    : number of stored entries, 0..DEPTH
//   FULL     : LEVEL == DEPTH
//   OVF      : sticky "a sample was dropped" flag
//   CLR_OVF  : synchronous clear of OVF (and of DROP_CNT)
//   DROP_CNT : saturating dropped-sample count, only when
//              FIR_OUT_FIFO_DROPCNT_EN is defined
// ---------------------------------------------------------------------------
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int DEPTH = FIR_OUT_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic [DW-1:0] DIN,
    input  logic          VIN,
    output logic [DW-1:0] DOUT,
    output logic          VOUT,
    input  logic          RDY,
    output logic [AW:0]   LEVEL,
    output logic          FULL,
    output logic          OVF,
    input  logic          CLR_OVF
`ifdef FIR_OUT_FIFO_DROPCNT_EN
    ,
    output logic [7:0]    DROP_CNT
`endif
);

    // Pointers carry one extra MSB so that equal low bits with differing
    // MSBs means full, and fully equal pointers means empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [DW-1:0] rd_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full buffer still accepts
    // a sample when the consumer is taking one.
    assign pop  = !empty && RDY;
    assign push = VIN && (!full || pop);
    assign drop = VIN && full && !pop;

    fifo_regfile #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (CLK),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (DIN),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    // Empty entries are never shown downstream; DOUT reads as zero then.
    assign DOUT  = empty ? '0 : rd_data;
    assign VOUT  = !empty;
    assign FULL  = full;
    assign LEVEL = wr_ptr - rd_ptr;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A drop takes priority over a clear in the same cycle so that no
    // lost sample can go unreported.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            OVF <= 1'b0;
        end else if (drop) begin
            OVF <= 1'b1;
        end else if (CLR_OVF) begin
            OVF <= 1'b0;
        end
    end

`ifdef FIR_OUT_FIFO_DROPCNT_EN
    // Saturating drop counter; a drop coinciding with a clear restarts the
    // count at one.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            DROP_CNT <= 8'd0;
        end else if (drop) begin
            if (CLR_OVF) begin
                DROP_CNT <= 8'd1;
            end else if (DROP_CNT != 8'hFF) begin
                DROP_CNT <= DROP_CNT + 8'd1;
            end
        end else if (CLR_OVF) begin
            DROP_CNT <= 8'd0;
        end
    end
`endif

endmodule

// File: doc/fir_out_fifo.md
Name: fir_out_fifo

Overview:
Output buffer directly downstream of the FIR filter. It captures every valid filter sample (DOUT/VOUT of the filter) and presents the samples to the next consumer through a valid/ready handshake. The filter has no backpressure, so this block absorbs consumer stalls. When the buffer is full, incoming samples are dropped and the drop is flagged.

Parameters:
DW, 8, sample width in bits; matches the filter output.
DEPTH, 8, number of entries; must be a power of 2 and at least 2.
AW, $clog2(DEPTH), pointer width; derived, not to be overridden.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_n  input  1  asynchronous active-low reset.
DIN  input  DW  sample from the filter.
VIN  input  1  DIN valid for one cycle; no ready is returned upstream.
DOUT  output  DW  head-of-queue sample.
VOUT  output  1  DOUT valid; equals not-empty.
RDY  input  1  consumer accepts DOUT this cycle.
LEVEL  output  AW+1  number of stored entries, 0..DEPTH.
FULL  output  1  LEVEL == DEPTH.
OVF  output  1  sticky flag: at least one sample has been dropped.
CLR_OVF  input  1  synchronous clear of OVF.

Behaviour:
- Reset (asynchronous, RST_n=0): write/read pointers=0, LEVEL=0, VOUT=0, FULL=0, OVF=0, DOUT=0. Memory contents are not reset.
- Storage: DEPTH x DW register array. Pointers are AW+1 bits, so empty and full are distinguished by the extra MSB.
- Push: occurs when VIN=1 and (not FULL, or a pop happens in the same cycle). The sample is written at wr_ptr and wr_ptr increments, wrapping modulo 2^(AW+1).
- Pop: occurs when VOUT=1 and RDY=1. rd_ptr increments.
- First-word-fall-through read:
  - DOUT = mem[rd_ptr] when not empty, else 0.
  - A push into an empty FIFO gives VOUT=1 on the next cycle (latency 1). There is no combinational VIN-to-VOUT path.
- LEVEL update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Simultaneous push+pop:
  - When full: both occur, LEVEL stays DEPTH, no drop.
  - When empty: only the push occurs, because VOUT=0 blocks the pop.
- Drop: VIN=1 while FULL=1 and no pop in that cycle. The sample is discarded, pointers are unchanged, and OVF is set at the next edge.
- OVF clearing:
  - CLR_OVF=1 clears OVF.
  - A drop in the same cycle as CLR_OVF wins, leaving OVF=1.
- RDY while empty: ignored; no underflow and no pointer movement.
- Reset mid-operation: all queued data is discarded immediately; after release the FIFO is empty.
- The block consumes filter output only; it never gates or delays the filter.

Optional Feature:
Macro FIR_OUT_FIFO_DROPCNT_EN.
- Defined: adds output DROP_CNT [7:0].
  - Counts dropped samples and saturates at 255.
  - Cleared by reset and by CLR_OVF.
  - A drop in the same cycle as CLR_OVF loads DROP_CNT=1.
- Undefined: port and counter are absent. OVF behaviour is unchanged.

Decomposition:
- Shared package fir_pkg holds:
  - the sample width constant FIR_DW=8;
  - the typedef fir_sample_t (logic [FIR_DW-1:0]);
  - the default FIR_OUT_FIFO_DEPTH=8.
- One sub-module, fifo_regfile: a parameterised DEPTH x DW register array with a synchronous write port and an asynchronous read port.
- Pointers, flags and counters stay in fir_out_fifo.

Test Plan:
- Reset, then VIN pulses with DIN=0x11,0x22,0x33 and RDY=1 continuously → VOUT rises one cycle after each push; DOUT sequence 0x11,0x22,0x33; LEVEL never exceeds 1; OVF=0.
- RDY=0, push 8 samples 0x01..0x08 → FULL=1, LEVEL=8. A 9th push of 0x09 → OVF=1, LEVEL=8. Then RDY=1 drains exactly 0x01..0x08 and VOUT=0 afterwards.
- Full FIFO with VIN=1 (DIN=0xAA) and RDY=1 in the same cycle → 0x01 popped, 0xAA stored, LEVEL stays 8, OVF unchanged.
- 20 cycles of push+pop with RDY toggling every other cycle → output order matches input order across pointer wrap; LEVEL tracks the model exactly.
- OVF=1, then CLR_OVF=1 with no drop → OVF=0. CLR_OVF=1 while a drop happens → OVF=1. With FIR_OUT_FIFO_DROPCNT_EN: 300 drops → DROP_CNT=255.
- LEVEL=5, assert RST_n=0 mid-cycle → VOUT, LEVEL and OVF go 0 immediately. After release, RDY=1 gives no output until the next push.
